// File: rtl/coef_loader_pkg.sv
// Shared types and helpers for the coefficient loader: issue FSM states,
// output coefficient width and the sign/zero extension function.
package coef_loader_pkg;

  localparam int OUT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_BUSY = 2'd2
  } issue_state_t;

  // Extends the low coef_w bits of raw to OUT_W bits; bits above coef_w are replaced.
  function automatic logic [OUT_W-1:0] extend_coef(
    input logic [OUT_W-1:0] raw,
    input int               coef_w,
    input bit               sign_ext
  );
    logic [OUT_W-1:0] res;
    logic             msb;
    res = raw;
    msb = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i == coef_w - 1) msb = raw[i];
      if (i >= coef_w) res[i] = sign_ext ? msb : 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/coef_frame_rx.sv
// Frame receiver: byte counter, little-endian shadow assembly and, when
// COEF_LOADER_CSUM_EN is defined, a trailing XOR checksum byte per frame.
module coef_frame_rx
  import coef_loader_pkg::*;
#(
  parameter int NUM_COEF = 2,
  parameter int COEF_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [7:0]                   in_byte,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic                         frame_clear,
  output logic                         in_ready,
  output logic                         frame_pending,
  output logic [NUM_COEF*COEF_W-1:0]   shadow_o,
  output logic                         load_err
);

  localparam int BPC         = COEF_W / 8;
  localparam int FRAME_BYTES = NUM_COEF * BPC;
`ifdef COEF_LOADER_CSUM_EN
  localparam int TOTAL_BYTES = FRAME_BYTES + 1;
`else
  localparam int TOTAL_BYTES = FRAME_BYTES;
`endif
  localparam int CNT_W = (TOTAL_BYTES < 2) ? 1 : $clog2(TOTAL_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_BYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [7:0]       shadow_q [FRAME_BYTES];
  logic [7:0]       shadow_d [FRAME_BYTES];
  logic [CNT_W-1:0] idx;
  logic             xfer;
`ifdef COEF_LOADER_CSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             err_q, err_d;
`endif

  assign in_ready      = ena && !pending_q;
  assign frame_pending = pending_q;
  assign xfer          = in_valid && in_ready;
  assign idx           = in_sof ? '0 : cnt_q;

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
`ifdef COEF_LOADER_CSUM_EN
    csum_d    = csum_q;
    err_d     = err_q;
`endif
    if (ena) begin
`ifdef COEF_LOADER_CSUM_EN
      err_d = 1'b0;
`endif
      if (frame_clear) pending_d = 1'b0;
      // A non-sof byte at index 0 is dropped so the receiver resyncs on the next sof.
      if (xfer && (in_sof || cnt_q != '0)) begin
        if (idx <= LAST_DATA) begin
          for (int i = 0; i < FRAME_BYTES; i++) begin
            if (idx == CNT_W'(i)) shadow_d[i] = in_byte;
          end
`ifdef COEF_LOADER_CSUM_EN
          csum_d = (idx == '0) ? in_byte : (csum_q ^ in_byte);
          cnt_d  = idx + 1'b1;
`else
          if (idx == LAST_DATA) begin
            pending_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = idx + 1'b1;
          end
`endif
        end else begin
          cnt_d = '0;
`ifdef COEF_LOADER_CSUM_EN
          if (in_byte == csum_q) begin
            pending_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            shadow_d = '{default: '0};
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '{default: '0};
`ifdef COEF_LOADER_CSUM_EN
      csum_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
`ifdef COEF_LOADER_CSUM_EN
      csum_q    <= csum_d;
      err_q     <= err_d;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_pack
      assign shadow_o[gi*8 +: 8] = shadow_q[gi];
    end
  endgenerate

`ifdef COEF_LOADER_CSUM_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: rtl/coef_loader.sv
// Coefficient loader top: double-buffered coefficient registers and the
// start_calc issue handshake. Optional checksum via COEF_LOADER_CSUM_EN.
module coef_loader
  import coef_loader_pkg::*;
#(
  parameter int NUM_COEF = 2,
  parameter int COEF_W   = 16,
  parameter int SIGN_EXT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  input  logic                      in_sof,
  output logic                      in_ready,
  output logic [NUM_COEF*OUT_W-1:0] coef_o,
  output logic                      start_calc,
  input  logic                      core_busy,
  output logic                      load_err
);

  logic [NUM_COEF*COEF_W-1:0] shadow;
  logic [NUM_COEF*OUT_W-1:0]  shadow_ext;
  logic                       frame_pending;
  logic                       issue;

  issue_state_t               state_q, state_d;
  logic [NUM_COEF*OUT_W-1:0]  coef_q, coef_d;
  logic                       start_calc_q, start_calc_d;

  coef_frame_rx #(
    .NUM_COEF (NUM_COEF),
    .COEF_W   (COEF_W)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .in_byte       (in_byte),
    .in_valid      (in_valid),
    .in_sof        (in_sof),
    .frame_clear   (issue),
    .in_ready      (in_ready),
    .frame_pending (frame_pending),
    .shadow_o      (shadow),
    .load_err      (load_err)
  );

  generate
    for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_ext
      assign shadow_ext[gi*OUT_W +: OUT_W] =
        extend_coef(OUT_W'(shadow[gi*COEF_W +: COEF_W]), COEF_W, SIGN_EXT != 0);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    coef_d       = coef_q;
    start_calc_d = start_calc_q;
    issue        = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (frame_pending && !core_busy) begin
            coef_d       = shadow_ext;
            start_calc_d = 1'b1;
            issue        = 1'b1;
            state_d      = S_ARM;
          end
        end
        S_ARM: begin
          if (core_busy) begin
            start_calc_d = 1'b0;
            state_d      = S_BUSY;
          end
        end
        S_BUSY: begin
          // Returning to idle takes one edge, so a waiting frame issues a cycle later.
          if (!core_busy) state_d = S_IDLE;
        end
        default: begin
          start_calc_d = 1'b0;
          state_d      = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      coef_q       <= '0;
      start_calc_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      coef_q       <= coef_d;
      start_calc_q <= start_calc_d;
    end
  end

  assign coef_o     = coef_q;
  assign start_calc = start_calc_q;

endmodule

// File: doc/coef_loader.md
COEF_LOADER -- requirements
Module: coef_loader

Interface
REQ-001 SHALL have parameter NUM_COEF, default 2: number of coefficients per frame, legal range 1..8.
REQ-002 SHALL have parameter COEF_W, default 16: received bits per coefficient, legal range 8..32 in multiples of 8; BPC = COEF_W/8 bytes per coefficient.
REQ-003 SHALL have parameter SIGN_EXT, default 1: 1 sign-extends each coefficient to 32 bits, 0 zero-extends.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port ena, input, 1: global enable; when 0, all state, counters and outputs hold.
REQ-007 SHALL have port in_byte, input, 8: serial parameter byte.
REQ-008 SHALL have port in_valid, input, 1: in_byte is valid this cycle.
REQ-009 SHALL have port in_sof, input, 1: qualified by in_valid; marks the first byte of a frame.
REQ-010 SHALL have port in_ready, output, 1: loader accepts a byte; a byte transfers when in_valid && in_ready.
REQ-011 SHALL have port coef_o, output, NUM_COEF*32: active signed coefficients; coefficient k occupies bits [32k+31:32k].
REQ-012 SHALL have port start_calc, output, 1: request to the core.
REQ-013 SHALL have port core_busy, input, 1: core is computing.
REQ-014 SHALL have port load_err, output, 1: one-cycle pulse on a rejected frame.

Function
REQ-015 SHALL assemble bytes little-endian within a coefficient, coefficient 0 first; a frame is NUM_COEF*BPC bytes (+1 checksum byte, see REQ-027).
REQ-016 SHALL write the frame into shadow registers; coef_o SHALL change only at the shadow-to-active copy.
REQ-017 SHALL drive in_ready = ena && !frame_pending; frame_pending SHALL set in the cycle after the last frame byte transfers.
REQ-018 SHALL restart at byte 0 on any accepted byte with in_sof=1, discarding the partial frame, with no error.
REQ-019 SHALL drop accepted bytes at byte index 0 with in_sof=0 (resync); no error.
REQ-020 SHALL implement the issue FSM: S_IDLE, S_ARM, S_BUSY.
REQ-021 In S_IDLE, when frame_pending && !core_busy, it SHALL copy shadow to coef_o, clear frame_pending, set start_calc and go to S_ARM, all in one edge.
REQ-022 In S_ARM, start_calc SHALL stay 1 until core_busy is sampled 1; it SHALL then clear start_calc and go to S_BUSY.
REQ-023 In S_BUSY, on core_busy sampled 0, it SHALL go to S_IDLE; a pending frame issues no earlier than the following cycle.
REQ-024 SHALL allow collection of the next frame in S_ARM/S_BUSY (double buffering); coef_o SHALL stay stable from start_calc rise until the S_BUSY exit.
REQ-025 SHALL form each coefficient as the COEF_W received bits extended to 32 bits per SIGN_EXT.

Reset
REQ-026 On rst_n=0: FSM=S_IDLE, byte counter=0, frame_pending=0, shadow=0, coef_o=0, start_calc=0, load_err=0; reset mid-frame or mid-handshake SHALL discard all progress.

Configuration
REQ-027 With COEF_LOADER_CSUM_EN defined, each frame SHALL carry a trailing byte equal to the XOR of all its data bytes; on mismatch, frame_pending stays 0, shadow is discarded, load_err pulses one cycle and the counter returns to 0; without it, there is no checksum byte and load_err is tied 0.

Structure
REQ-028 Package coef_loader_pkg SHALL hold the issue-state enum, localparam OUT_W=32 and the sign/zero extension function.
REQ-029 Byte assembly, counter, shadow and checksum SHALL live in sub-module coef_frame_rx; coef_loader holds the issue FSM and active registers.

Verification
REQ-030 Defaults, no CSUM: bytes 34 12 FF 80 (sof on first), core idle -> start_calc rises 1 cycle after pending sets; coef_o = {FFFF80FF, 00001234}.
REQ-031 SIGN_EXT=0, same bytes -> coef_o = {000080FF, 00001234}.
REQ-032 core_busy held 1 while a frame completes -> no start_calc and in_ready=0 until core_busy falls, then issue.
REQ-033 A second frame sent during S_BUSY -> coef_o unchanged until S_BUSY exits, then a new start_calc with the second values.
REQ-034 in_sof on the 3rd byte of a frame -> partial frame discarded; the following 4 bytes form the frame; load_err stays 0.
REQ-035 CSUM_EN: bytes 01 02 03 04 with csum 04 -> issue; with csum 05 -> load_err pulse, coef_o unchanged, no start_calc; ena=0 mid-frame -> state frozen.
